// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: a direct-mapped one-word-per-line instruction
// cache looked up at the internal fetch PC, a refill path to the memory
// arbiter, and a FIFO fetch queue that feeds issue through a valid/ack
// handshake.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   RUN   | look up fetch PC each cycle while the queue has space
//   MISS  | refill outstanding for mem_addr; wait for mem_ready
module fetch_queue_unit #(
    parameter int ADDR_W   = 32,
    parameter int INST_W   = 32,
    parameter int IDX_BITS = 8,
    parameter int FQ_DEPTH = 4,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    input  logic              invalidate,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [INST_W-1:0] mem_inst,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pred_pc,
    input  logic              pred_taken,
    input  logic [ADDR_W-1:0] pred_target,
    output logic              issue_valid,
    output logic [INST_W-1:0] issue_inst,
    output logic [ADDR_W-1:0] issue_pc,
    output logic              issue_pred_taken,
    input  logic              issue_ack,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int LINES  = 1 << IDX_BITS;
    localparam int TAG_W  = ADDR_W - IDX_BITS - 2;
    localparam int PTR_W  = $clog2(FQ_DEPTH);
    localparam int QCNT_W = PTR_W + 1;

    localparam logic [QCNT_W-1:0] DEPTH_C  = QCNT_W'(FQ_DEPTH);
    localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [QCNT_W-1:0] QCNT_ONE = QCNT_W'(1);

    typedef enum logic {
        RUN  = 1'b0,
        MISS = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_W-1:0] fetch_pc;

    // cache arrays: valid bits are reset, tag/data only written on refill
    logic [LINES-1:0]  line_valid;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [INST_W-1:0] data_mem [LINES];

    // fetch queue storage
    logic [INST_W-1:0]   q_inst [FQ_DEPTH];
    logic [ADDR_W-1:0]   q_pc   [FQ_DEPTH];
    logic [FQ_DEPTH-1:0] q_taken;
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [QCNT_W-1:0]   count;

    logic [IDX_BITS-1:0] look_idx;
    logic [TAG_W-1:0]    look_tag;
    logic [INST_W-1:0]   look_data;
    logic [IDX_BITS-1:0] fill_idx;
    logic [TAG_W-1:0]    fill_tag;
    logic                has_space;

    logic lookup;
    logic hit;
    logic miss;
    logic enq;
    logic deq;
    logic refill;

    // word-offset bits never select anything in a one-word-line cache
    logic offset_bits_unused;

    assign look_idx  = fetch_pc[IDX_BITS+1:2];
    assign look_tag  = fetch_pc[ADDR_W-1:IDX_BITS+2];
    assign look_data = data_mem[look_idx];
    assign fill_idx  = mem_addr[IDX_BITS+1:2];
    assign fill_tag  = mem_addr[ADDR_W-1:IDX_BITS+2];
    assign has_space = (count < DEPTH_C);

    assign offset_bits_unused = ^{fetch_pc[1:0], mem_addr[1:0]};

    assign pred_pc          = fetch_pc;
    assign issue_valid      = (count != '0);
    assign issue_inst       = q_inst[head];
    assign issue_pc         = q_pc[head];
    assign issue_pred_taken = q_taken[head];

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // next-state: a miss parks the fetcher until the refill returns; flush
    // never aborts an outstanding refill
    always_comb begin
        state_next = state;
        if (rdy) begin
            case (state)
                RUN:     if (miss) state_next = MISS;
                MISS:    if (mem_ready) state_next = RUN;
                default: state_next = RUN;
            endcase
        end
    end

    // per-cycle control strobes; queue space is judged on the count at the
    // start of the cycle, and a same-cycle invalidate turns a lookup into a miss
    always_comb begin
        lookup = 1'b0;
        hit    = 1'b0;
        miss   = 1'b0;
        enq    = 1'b0;
        deq    = 1'b0;
        refill = 1'b0;
        if (rdy) begin
            deq    = issue_valid && issue_ack && !flush;
            refill = (state == MISS) && mem_ready;
            if (state == RUN && !flush && has_space) begin
                lookup = 1'b1;
                if (line_valid[look_idx] && (tag_mem[look_idx] == look_tag) && !invalidate) begin
                    hit = 1'b1;
                end else begin
                    miss = 1'b1;
                end
                // an all-zero word is treated as a bubble and dropped
                enq = hit && (look_data != '0);
            end
        end
    end

    // fetch PC: redirect beats sequencing; only a hit advances it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= '0;
        end else if (rdy) begin
            if (flush) begin
                fetch_pc <= flush_pc;
            end else if (hit) begin
                fetch_pc <= pred_taken ? pred_target : (fetch_pc + PC_STEP);
            end
        end
    end

    // refill request: one-cycle pulse, address held for the whole refill
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req  <= 1'b0;
            mem_addr <= '0;
        end else if (rdy) begin
            mem_req <= miss;
            if (miss) begin
                mem_addr <= fetch_pc;
            end
        end
    end

    // valid bits: invalidate wins over a same-cycle refill
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_valid <= '0;
        end else if (rdy) begin
            if (invalidate) begin
                line_valid <= '0;
            end else if (refill) begin
                line_valid[fill_idx] <= 1'b1;
            end
        end
    end

    // tag/data write on refill; data is kept even if the line is invalidated
    always_ff @(posedge clk) begin
        if (refill) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= mem_inst;
        end
    end

    // queue pointers and occupancy; flush drops everything including a
    // same-cycle enqueue
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy) begin
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (enq) tail <= tail + PTR_ONE;
                if (deq) head <= head + PTR_ONE;
                case ({enq, deq})
                    2'b10:   count <= count + QCNT_ONE;
                    2'b01:   count <= count - QCNT_ONE;
                    default: count <= count;
                endcase
            end
        end
    end

    // queue payload write at the tail
    always_ff @(posedge clk) begin
        if (enq) begin
            q_inst[tail]  <= look_data;
            q_pc[tail]    <= fetch_pc;
            q_taken[tail] <= pred_taken;
        end
    end

    // hit/miss counters, free-running and wrapping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (rdy) begin
            if (hit)  hit_count  <= hit_count + CNT_ONE;
            if (miss) miss_count <= miss_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
module tb_fetch_queue_unit;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        flush;
    logic [31:0] flush_pc;
    logic        invalidate;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_inst;
    logic        mem_ready;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        issue_valid;
    logic [31:0] issue_inst;
    logic [31:0] issue_pc;
    logic        issue_pred_taken;
    logic        issue_ack;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    logic        jump_en;
    logic [31:0] jump_src;
    logic [31:0] jump_tgt;
    logic        inv_race;

    int tests_run;
    int tests_failed;

    fetch_queue_unit dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .flush            (flush),
        .flush_pc         (flush_pc),
        .invalidate       (invalidate),
        .mem_req          (mem_req),
        .mem_addr         (mem_addr),
        .mem_inst         (mem_inst),
        .mem_ready        (mem_ready),
        .pred_pc          (pred_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .issue_valid      (issue_valid),
        .issue_inst       (issue_inst),
        .issue_pc         (issue_pc),
        .issue_pred_taken (issue_pred_taken),
        .issue_ack        (issue_ack),
        .hit_count        (hit_count),
        .miss_count       (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // predictor: single programmable taken branch
    assign pred_taken  = jump_en && (pred_pc == jump_src);
    assign pred_target = jump_tgt;
    assign invalidate  = inv_race;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h80) return 32'h0;
        return {a[23:0], 8'h13};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // memory model: mem_ready sampled on the third edge after the request
    // edge; the first refill of 0x200 coincides with an invalidate
    initial begin : responder
        logic [31:0] a;
        bit race_used;
        race_used = 1'b0;
        mem_ready = 1'b0;
        mem_inst  = 32'h0;
        inv_race  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req === 1'b1) begin
                a = mem_addr;
                repeat (2) begin
                    @(posedge clk);
                    #1;
                end
                mem_inst  = mem_word(a);
                mem_ready = 1'b1;
                if (a == 32'h200 && !race_used) begin
                    inv_race  = 1'b1;
                    race_used = 1'b1;
                end
                @(posedge clk);
                #1;
                mem_ready = 1'b0;
                inv_race  = 1'b0;
                mem_inst  = 32'h0;
            end
        end
    end

    task automatic do_flush(input logic [31:0] pc);
        flush    = 1'b1;
        flush_pc = pc;
        step();
        flush    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; rdy = 1'b1; flush = 1'b0; flush_pc = 32'h0;
        issue_ack = 1'b0; jump_en = 1'b0; jump_src = 32'h0; jump_tgt = 32'h0;
        repeat (3) step();
        tests_run++; if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_req: got %b exp 0", mem_req); end
        tests_run++; if (mem_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_mem_addr: got %h exp 0", mem_addr); end
        tests_run++; if (issue_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b exp 0", issue_valid); end
        tests_run++; if (pred_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_pc: got %h exp 0", pred_pc); end
        tests_run++; if (hit_count !== 32'h0 || miss_count !== 32'h0) begin tests_failed++; $display("FAIL reset_counts: got %0d/%0d exp 0/0", hit_count, miss_count); end
        rst = 1'b1;
    endtask

    task automatic test_cold_start();
        step();
        tests_run++; if (mem_req !== 1'b1) begin tests_failed++; $display("FAIL cold_req: got %b exp 1", mem_req); end
        tests_run++; if (mem_addr !== 32'h0) begin tests_failed++; $display("FAIL cold_addr: got %h exp 0", mem_addr); end
        step(); step();
        tests_run++; if (mem_req !== 1'b0 || issue_valid !== 1'b0) begin tests_failed++; $display("FAIL cold_wait: got req=%b valid=%b exp 0/0", mem_req, issue_valid); end
        step();
        tests_run++; if (issue_valid !== 1'b0) begin tests_failed++; $display("FAIL cold_refill_cycle: got %b exp 0", issue_valid); end
        step();
        tests_run++; if (issue_valid !== 1'b1 || issue_inst !== 32'h13 || issue_pc !== 32'h0) begin tests_failed++; $display("FAIL cold_issue: got v=%b inst=%h pc=%h exp 1/00000013/0", issue_valid, issue_inst, issue_pc); end
        tests_run++; if (miss_count !== 32'd1 || hit_count !== 32'd1) begin tests_failed++; $display("FAIL cold_counts: got h=%0d m=%0d exp 1/1", hit_count, miss_count); end
    endtask

    task automatic test_preload();
        int n;
        issue_ack = 1'b1;
        n = 0;
        while (pred_pc !== 32'h24 && n < 300) begin step(); n++; end
        tests_run++; if (pred_pc !== 32'h24) begin tests_failed++; $display("FAIL preload_timeout: got pc %h exp 00000024", pred_pc); end
        issue_ack = 1'b0;
        do_flush(32'h0);
        tests_run++; if (issue_valid !== 1'b0 || pred_pc !== 32'h0) begin tests_failed++; $display("FAIL preload_flush: got v=%b pc=%h exp 0/0", issue_valid, pred_pc); end
        tests_run++; if (hit_count !== 32'd9 || miss_count !== 32'd9) begin tests_failed++; $display("FAIL preload_counts: got h=%0d m=%0d exp 9/9", hit_count, miss_count); end
    endtask

    task automatic test_backpressure();
        repeat (4) step();
        tests_run++; if (pred_pc !== 32'h10 || issue_pc !== 32'h0 || issue_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_full: got pc=%h head=%h v=%b exp 10/0/1", pred_pc, issue_pc, issue_valid); end
        step(); step();
        tests_run++; if (pred_pc !== 32'h10 || mem_req !== 1'b0 || hit_count !== 32'd13) begin tests_failed++; $display("FAIL bp_frozen: got pc=%h req=%b h=%0d exp 10/0/13", pred_pc, mem_req, hit_count); end
        issue_ack = 1'b1;
        step();
        issue_ack = 1'b0;
        tests_run++; if (issue_pc !== 32'h4 || pred_pc !== 32'h10) begin tests_failed++; $display("FAIL bp_first_ack: got head=%h pc=%h exp 4/10", issue_pc, pred_pc); end
        step();
        tests_run++; if (pred_pc !== 32'h14 || hit_count !== 32'd14) begin tests_failed++; $display("FAIL bp_refill_slot: got pc=%h h=%0d exp 14/14", pred_pc, hit_count); end
    endtask

    task automatic test_streaming();
        logic [31:0] exp_pc;
        issue_ack = 1'b1;
        do_flush(32'h0);
        tests_run++; if (issue_valid !== 1'b0 || pred_pc !== 32'h0) begin tests_failed++; $display("FAIL stream_flush: got v=%b pc=%h exp 0/0", issue_valid, pred_pc); end
        for (int i = 0; i < 4; i++) begin
            step();
            exp_pc = 32'(i * 4);
            tests_run++; if (issue_valid !== 1'b1 || issue_pc !== exp_pc || mem_req !== 1'b0) begin tests_failed++; $display("FAIL stream_%0d: got v=%b pc=%h req=%b exp 1/%h/0", i, issue_valid, issue_pc, mem_req, exp_pc); end
        end
        issue_ack = 1'b0;
        repeat (10) step();
        tests_run++; if (hit_count !== 32'd21 || miss_count !== 32'd9 || pred_pc !== 32'h1c) begin tests_failed++; $display("FAIL stream_counts: got h=%0d m=%0d pc=%h exp 21/9/1c", hit_count, miss_count, pred_pc); end
    endtask

    task automatic test_predicted_jump();
        int n;
        jump_en = 1'b1; jump_src = 32'h8; jump_tgt = 32'h40;
        do_flush(32'h0);
        repeat (3) step();
        tests_run++; if (pred_pc !== 32'h40) begin tests_failed++; $display("FAIL jump_redirect: got %h exp 00000040", pred_pc); end
        issue_ack = 1'b1;
        step();
        tests_run++; if (issue_pc !== 32'h4 || issue_pred_taken !== 1'b0) begin tests_failed++; $display("FAIL jump_seq_entry: got pc=%h t=%b exp 4/0", issue_pc, issue_pred_taken); end
        tests_run++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin tests_failed++; $display("FAIL jump_target_miss: got req=%b addr=%h exp 1/40", mem_req, mem_addr); end
        step();
        tests_run++; if (issue_pc !== 32'h8 || issue_pred_taken !== 1'b1) begin tests_failed++; $display("FAIL jump_taken_entry: got pc=%h t=%b exp 8/1", issue_pc, issue_pred_taken); end
        step();
        issue_ack = 1'b0;
        n = 0;
        while (issue_valid !== 1'b1 && n < 20) begin step(); n++; end
        tests_run++; if (issue_valid !== 1'b1 || issue_pc !== 32'h40 || issue_inst !== 32'h4013 || issue_pred_taken !== 1'b0) begin tests_failed++; $display("FAIL jump_target_entry: got v=%b pc=%h inst=%h t=%b exp 1/40/4013/0", issue_valid, issue_pc, issue_inst, issue_pred_taken); end
        repeat (40) step();
        tests_run++; if (hit_count !== 32'd28 || miss_count !== 32'd13 || pred_pc !== 32'h50) begin tests_failed++; $display("FAIL jump_counts: got h=%0d m=%0d pc=%h exp 28/13/50", hit_count, miss_count, pred_pc); end
    endtask

    task automatic test_flush_during_miss();
        int n;
        jump_src = 32'h18; jump_tgt = 32'h100;
        do_flush(32'h10);
        repeat (3) step();
        step();
        tests_run++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || issue_valid !== 1'b1) begin tests_failed++; $display("FAIL fm_miss: got req=%b addr=%h v=%b exp 1/100/1", mem_req, mem_addr, issue_valid); end
        do_flush(32'h20);
        tests_run++; if (issue_valid !== 1'b0 || pred_pc !== 32'h20) begin tests_failed++; $display("FAIL fm_flush: got v=%b pc=%h exp 0/20", issue_valid, pred_pc); end
        n = 0;
        while (issue_valid !== 1'b1 && n < 20) begin step(); n++; end
        tests_run++; if (issue_valid !== 1'b1 || issue_pc !== 32'h20) begin tests_failed++; $display("FAIL fm_next_issue: got v=%b pc=%h exp 1/20", issue_valid, issue_pc); end
        repeat (40) step();
        tests_run++; if (hit_count !== 32'd35 || miss_count !== 32'd17) begin tests_failed++; $display("FAIL fm_counts: got h=%0d m=%0d exp 35/17", hit_count, miss_count); end
        jump_src = 32'h100; jump_tgt = 32'h100;
        do_flush(32'h100);
        step();
        tests_run++; if (issue_valid !== 1'b1 || issue_pc !== 32'h100 || issue_inst !== 32'h10013 || mem_req !== 1'b0) begin tests_failed++; $display("FAIL fm_refill_kept: got v=%b pc=%h inst=%h req=%b exp 1/100/10013/0", issue_valid, issue_pc, issue_inst, mem_req); end
        repeat (10) step();
        tests_run++; if (hit_count !== 32'd39 || miss_count !== 32'd17) begin tests_failed++; $display("FAIL fm_loop_counts: got h=%0d m=%0d exp 39/17", hit_count, miss_count); end
    endtask

    task automatic test_invalidate_race();
        int n;
        jump_src = 32'h200; jump_tgt = 32'h200;
        do_flush(32'h200);
        step();
        tests_run++; if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin tests_failed++; $display("FAIL ir_first_req: got req=%b addr=%h exp 1/200", mem_req, mem_addr); end
        repeat (3) step();
        tests_run++; if (mem_req !== 1'b0 || issue_valid !== 1'b0) begin tests_failed++; $display("FAIL ir_refill_edge: got req=%b v=%b exp 0/0", mem_req, issue_valid); end
        step();
        tests_run++; if (mem_req !== 1'b1 || mem_addr !== 32'h200 || miss_count !== 32'd19) begin tests_failed++; $display("FAIL ir_second_req: got req=%b addr=%h m=%0d exp 1/200/19", mem_req, mem_addr, miss_count); end
        n = 0;
        while (issue_valid !== 1'b1 && n < 20) begin step(); n++; end
        tests_run++; if (issue_valid !== 1'b1 || issue_pc !== 32'h200 || issue_inst !== 32'h20013) begin tests_failed++; $display("FAIL ir_issue: got v=%b pc=%h inst=%h exp 1/200/20013", issue_valid, issue_pc, issue_inst); end
        repeat (10) step();
        tests_run++; if (hit_count !== 32'd43 || miss_count !== 32'd19) begin tests_failed++; $display("FAIL ir_counts: got h=%0d m=%0d exp 43/19", hit_count, miss_count); end
    endtask

    task automatic test_freeze_and_zero_word();
        int n;
        rdy = 1'b0; issue_ack = 1'b1; flush = 1'b1; flush_pc = 32'h80;
        repeat (3) step();
        tests_run++; if (pred_pc !== 32'h200 || issue_valid !== 1'b1 || hit_count !== 32'd43) begin tests_failed++; $display("FAIL freeze: got pc=%h v=%b h=%0d exp 200/1/43", pred_pc, issue_valid, hit_count); end
        jump_src = 32'h84; jump_tgt = 32'h84; issue_ack = 1'b0;
        rdy = 1'b1;
        step();
        flush = 1'b0;
        tests_run++; if (issue_valid !== 1'b0 || pred_pc !== 32'h80) begin tests_failed++; $display("FAIL unfreeze_flush: got v=%b pc=%h exp 0/80", issue_valid, pred_pc); end
        n = 0;
        while (issue_valid !== 1'b1 && n < 40) begin step(); n++; end
        tests_run++; if (issue_valid !== 1'b1 || issue_pc !== 32'h84 || issue_inst !== 32'h8413) begin tests_failed++; $display("FAIL zero_word_skip: got v=%b pc=%h inst=%h exp 1/84/8413", issue_valid, issue_pc, issue_inst); end
        repeat (10) step();
        tests_run++; if (hit_count !== 32'd48 || miss_count !== 32'd21) begin tests_failed++; $display("FAIL zero_word_counts: got h=%0d m=%0d exp 48/21", hit_count, miss_count); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_cold_start();
        test_preload();
        test_backpressure();
        test_streaming();
        test_predicted_jump();
        test_flush_during_miss();
        test_invalidate_race();
        test_freeze_and_zero_word();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
